task_dispatcher: RTL
====================

// Module: task_dispatcher
// PURPOSE
//  Control-side scheduler for the per-node self-awareness pollers. Holds one program slot per node
//  and a FIFO of pending program base addresses pushed by the host. Assigns queued programs to idle
//  nodes. Answers node AXI-lite polls (read slot) and completion writes (clear slot).
//  Sits on the AXI-lite interconnect at the control address space (INDEX_CONTROL=1, INDEX_PROG=1).
// PARAMETERS
//  NUM_NODES   4   number of processing nodes / slots (1..32)
//  FIFO_DEPTH  8   pending-task FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1         single clock, all logic on posedge
//  res         in   1         synchronous reset, active-high
//  s_axi       if   -         if_axi_light.slave; node poll/complete traffic
//  task_valid  in   1         host offers a program base address
//  task_addr   in   AXI_DATA  program base address (0 illegal)
//  task_ready  out  1         FIFO not full; push when valid&ready
//  task_err    out  1         1-cycle pulse: pushed task_addr==0, dropped
//  done_valid  out  1         1-cycle pulse: a node released its slot
//  done_id     out  5         node id for done_valid
//  busy_mask   out  NUM_NODES bit i = slot i holds a program
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries
// BEHAVIOUR
//  Reset: all slots=0, FIFO empty, rr_ptr=0, busy_mask=0, task_ready=1, task_err=0, done_valid=0,
//   done_id=0. All AXI valids/readys=0, AXI FSM=IDLE. Reset mid-transaction aborts it; no response.
//  Address decode: node id = addr[PICO_MSB:PICO_LSB]. Legal iff INDEX_CONTROL=1, INDEX_PROG=1 and
//   id<NUM_NODES; otherwise resp=SLVERR, rdata=0, no state change.
//  AXI FSM: IDLE, RD_RESP, WR_DATA, WR_RESP.
//   IDLE: AW has priority over AR when both valid. AR: arready=1 for one cycle, latch slot -> RD_RESP.
//    AW&W both valid: accept both in the same cycle -> WR_RESP. AW only: accept AW -> WR_DATA.
//   RD_RESP: rvalid=1, rdata=latched slot, rresp=OKAY; hold until rready -> IDLE.
//    The read response comes one cycle after the AR handshake.
//   WR_DATA: wready=1 until wvalid -> WR_RESP. The slot update happens on W acceptance.
//   WR_RESP: bvalid=1 until bready -> IDLE. At most one outstanding transaction.
//  Write semantics (legal address): wdata==0 and slot!=0 -> slot=0, done_valid=1, done_id=id, OKAY.
//   wdata==0 and slot==0 -> OKAY, no pulse. wdata!=0 -> SLVERR, slot unchanged (host-only assign).
//   wstrb ignored.
//  FIFO push: push when task_valid&task_ready. addr==0 is not stored; task_err pulses the next cycle.
//   Full: task_ready=0, no write.
//  Dispatch (every cycle): if FIFO non-empty and some slot idle, pick the first idle slot searching
//   from rr_ptr upward with wrap. Write head into it, pop, rr_ptr=(chosen+1)%NUM_NODES.
//   At most one dispatch per cycle.
//  Idle slot: slot==0 and not being cleared this cycle. A slot cleared in cycle N is dispatchable from N+1.
//  Simultaneous push+pop: count unchanged. Push when full+pop same cycle: not accepted (ready is registered).
//  Read racing dispatch to the same slot: the read returns the pre-dispatch value (0); the node re-polls.
//  Pointers wrap mod FIFO_DEPTH. Count is 0..FIFO_DEPTH, never over/underflows.
//  busy_mask[i] = (slot[i]!=0), registered alongside slots.
// STRUCTURE
//  Package self_awareness_pkg: INDEX_CONTROL, INDEX_PROG, PICO_MSB=6, PICO_LSB=2,
//   AXI resp codes (OKAY=2'b00, SLVERR=2'b10), axi_state_t enum.
//   The node-side poller imports the same package.
//  Sub-module task_fifo (sync FIFO, WIDTH/DEPTH params, push/pop/full/empty/count).
//   Slot array, round-robin pick and the AXI FSM stay in task_dispatcher.
// TESTING
//  1 Reset, push 0x1000 with nodes idle -> slot0=0x1000 within 2 cycles, busy_mask=0001.
//    Read of addr node0 -> rdata 0x1000, OKAY.
//  2 Push 0x1000,0x2000,0x3000,0x4000,0x5000 (NUM_NODES=4) -> slots 0..3 filled in order,
//    fifo_count=1. Node2 writes 0 -> done_id=2, slot2=0x5000 next cycle.
//  3 Fill FIFO (8 entries) with all slots busy -> task_ready=0. The 9th push is not accepted.
//    One completion -> count=7, task_ready=1.
//  4 Push task_addr=0 -> task_err pulse, fifo_count unchanged. Write 0x1234 to node1 -> SLVERR,
//    slot intact. Read node id 5 -> SLVERR, rdata 0.
//  5 AW and W in different cycles with bready held low 3 cycles -> bvalid held, single done pulse.
//    AR and AW same cycle -> write serviced first.
//  6 Assert res during RD_RESP with slots busy -> rvalid=0, all slots 0, busy_mask=0,
//    task_ready=1 next cycle.

Source files
------------

// File: rtl/self_awareness_pkg.sv
// Shared definitions for the task dispatcher and the node-side pollers.
// Covers the control-space address decode, AXI-lite response codes and bus FSM states.
package self_awareness_pkg;

   localparam int AXI_ADDR_W    = 32;
   localparam int AXI_DATA_W    = 32;
   localparam int INDEX_CONTROL = 8;
   localparam int INDEX_PROG    = 7;
   localparam int PICO_MSB      = 6;
   localparam int PICO_LSB      = 2;
   localparam int ID_W          = PICO_MSB - PICO_LSB + 1;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      AXI_IDLE,
      AXI_RD_RESP,
      AXI_WR_DATA,
      AXI_WR_RESP
   } axi_state_t;

   function automatic logic [ID_W-1:0] node_id(input logic [AXI_ADDR_W-1:0] addr);
      return addr[PICO_MSB:PICO_LSB];
   endfunction

   // A slot address must sit in the control/program window and name an existing node.
   function automatic logic addr_legal(input logic [AXI_ADDR_W-1:0] addr, input int num_nodes);
      return addr[INDEX_CONTROL] && addr[INDEX_PROG] && (int'(node_id(addr)) < num_nodes);
   endfunction

endpackage

// File: rtl/if_axi_light.sv
// Minimal AXI-lite bundle shared by the pollers (master) and the dispatcher (slave).
interface if_axi_light;
   import self_awareness_pkg::*;

   logic                  awvalid;
   logic                  awready;
   logic [AXI_ADDR_W-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [AXI_DATA_W-1:0] wdata;
   logic [3:0]            wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [AXI_ADDR_W-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [AXI_DATA_W-1:0] rdata;
   logic [1:0]            rresp;

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/task_fifo.sv
// Synchronous FIFO holding pending program base addresses; head is visible on dout.
// Push when full and pop when empty are ignored, so count stays within 0..DEPTH.
module task_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];
   assign count   = count_q;

   // NOTE: storage has no reset; entries are only meaningful between rd_ptr and wr_ptr.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/task_dispatcher.sv
// Holds one program slot per node, queues host programs and hands them to idle nodes round-robin.
// Nodes poll their slot over AXI-lite and release it by writing zero.
module task_dispatcher
   import self_awareness_pkg::*;
#(
   parameter int NUM_NODES  = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          res,
   if_axi_light.slave                    s_axi,
   input  logic                          task_valid,
   input  logic [AXI_DATA_W-1:0]         task_addr,
   output logic                          task_ready,
   output logic                          task_err,
   output logic                          done_valid,
   output logic [ID_W-1:0]               done_id,
   output logic [NUM_NODES-1:0]          busy_mask,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

   axi_state_t            state_q, state_d;
   logic [AXI_ADDR_W-1:0] aw_addr_q;
   logic [AXI_ADDR_W-1:0] w_addr;
   logic [AXI_DATA_W-1:0] rdata_q;
   logic [1:0]            rresp_q;
   logic [1:0]            bresp_q;
   logic                  aw_take, w_take, ar_take;

   logic [AXI_DATA_W-1:0] slot_q [NUM_NODES];
   logic [AXI_DATA_W-1:0] slot_d [NUM_NODES];
   logic [NUM_NODES-1:0]  busy_q;
   logic [NUM_NODES-1:0]  slot_clear;
   logic [NUM_NODES-1:0]  idle;
   logic [NODE_W-1:0]     rr_ptr_q;
   logic                  task_err_q, done_valid_q;
   logic [ID_W-1:0]       done_id_q;

   logic [ID_W-1:0]       wr_id, rd_id;
   logic                  wr_legal, rd_legal;
   logic [1:0]            wr_resp;
   logic [AXI_DATA_W-1:0] rd_slot;

   logic                  pick_valid;
   int                    pick_idx;
   logic                  dispatch;
   logic                  fifo_push, fifo_full, fifo_empty;
   logic [AXI_DATA_W-1:0] fifo_head;
   logic                  unused_wstrb;

   assign unused_wstrb = ^s_axi.wstrb;

   assign task_ready = !fifo_full;
   assign fifo_push  = task_valid && task_ready && (task_addr != '0);

   task_fifo #(.WIDTH(AXI_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .res   (res),
      .push  (fifo_push),
      .din   (task_addr),
      .pop   (dispatch),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Bus handshakes; readies are held low while res is asserted.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d       = state_q;
      s_axi.awready = 1'b0;
      s_axi.wready  = 1'b0;
      s_axi.arready = 1'b0;
      s_axi.rvalid  = 1'b0;
      s_axi.bvalid  = 1'b0;
      aw_take       = 1'b0;
      w_take        = 1'b0;
      ar_take       = 1'b0;
      w_addr        = aw_addr_q;
      if (!res) begin
         case (state_q)
            AXI_IDLE: begin
               if (s_axi.awvalid) begin
                  s_axi.awready = 1'b1;
                  aw_take       = 1'b1;
                  if (s_axi.wvalid) begin
                     s_axi.wready = 1'b1;
                     w_take       = 1'b1;
                     w_addr       = s_axi.awaddr;
                     state_d      = AXI_WR_RESP;
                  end else begin
                     state_d      = AXI_WR_DATA;
                  end
               end else if (s_axi.arvalid) begin
                  s_axi.arready = 1'b1;
                  ar_take       = 1'b1;
                  state_d       = AXI_RD_RESP;
               end
            end
            AXI_RD_RESP: begin
               s_axi.rvalid = 1'b1;
               if (s_axi.rready) state_d = AXI_IDLE;
            end
            AXI_WR_DATA: begin
               s_axi.wready = 1'b1;
               if (s_axi.wvalid) begin
                  w_take  = 1'b1;
                  state_d = AXI_WR_RESP;
               end
            end
            AXI_WR_RESP: begin
               s_axi.bvalid = 1'b1;
               if (s_axi.bready) state_d = AXI_IDLE;
            end
            default: state_d = AXI_IDLE;
         endcase
      end
   end

   assign s_axi.rdata = rdata_q;
   assign s_axi.rresp = rresp_q;
   assign s_axi.bresp = bresp_q;

   // Address decode, slot release and round-robin pick of the next idle slot.
   always_comb begin
      rd_id    = node_id(s_axi.araddr);
      rd_legal = addr_legal(s_axi.araddr, NUM_NODES);
      wr_id    = node_id(w_addr);
      wr_legal = addr_legal(w_addr, NUM_NODES);
      wr_resp  = (wr_legal && (s_axi.wdata == '0)) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      rd_slot  = '0;
      for (int i = 0; i < NUM_NODES; i++) begin
         if (int'(rd_id) == i) rd_slot = slot_q[i];
         slot_clear[i] = w_take && wr_legal && (int'(wr_id) == i) &&
                         (s_axi.wdata == '0) && (slot_q[i] != '0);
         idle[i]       = (slot_q[i] == '0) && !slot_clear[i];
      end
      pick_valid = 1'b0;
      pick_idx   = 0;
      for (int k = 0; k < NUM_NODES; k++) begin
         if (!pick_valid && idle[(int'(rr_ptr_q) + k) % NUM_NODES]) begin
            pick_valid = 1'b1;
            pick_idx   = (int'(rr_ptr_q) + k) % NUM_NODES;
         end
      end
      dispatch = pick_valid && !fifo_empty;
      for (int i = 0; i < NUM_NODES; i++) begin
         slot_d[i] = slot_q[i];
         if (slot_clear[i]) slot_d[i] = '0;
         if (dispatch && (pick_idx == i)) slot_d[i] = fifo_head;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q   <= AXI_IDLE;
         aw_addr_q <= '0;
         rdata_q   <= '0;
         rresp_q   <= AXI_RESP_OKAY;
         bresp_q   <= AXI_RESP_OKAY;
      end else begin
         state_q <= state_d;
         if (aw_take) aw_addr_q <= s_axi.awaddr;
         if (ar_take) begin
            rdata_q <= rd_legal ? rd_slot : '0;
            rresp_q <= rd_legal ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
         end
         if (w_take) bresp_q <= wr_resp;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         for (int i = 0; i < NUM_NODES; i++) slot_q[i] <= '0;
         busy_q       <= '0;
         rr_ptr_q     <= '0;
         task_err_q   <= 1'b0;
         done_valid_q <= 1'b0;
         done_id_q    <= '0;
      end else begin
         for (int i = 0; i < NUM_NODES; i++) begin
            slot_q[i] <= slot_d[i];
            busy_q[i] <= (slot_d[i] != '0);
         end
         if (dispatch) rr_ptr_q <= NODE_W'((pick_idx + 1) % NUM_NODES);
         task_err_q   <= task_valid && task_ready && (task_addr == '0);
         done_valid_q <= |slot_clear;
         if (|slot_clear) done_id_q <= wr_id;
      end
   end

   assign busy_mask  = busy_q;
   assign task_err   = task_err_q;
   assign done_valid = done_valid_q;
   assign done_id    = done_id_q;

endmodule
